// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm clock controller.
//   mode_t         user-facing mode encoding (driven on the mode output)
//   *_MAX / *_W    field limits and widths for hh:mm:ss
//   next_mode()    mode advance order used by btn_mode
package alarm_pkg;

  typedef enum logic [2:0] {
    RUN         = 3'd0,
    SET_TIME_H  = 3'd1,
    SET_TIME_M  = 3'd2,
    SET_ALARM_H = 3'd3,
    SET_ALARM_M = 3'd4
  } mode_t;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  // RUN -> SET_TIME_H -> SET_TIME_M -> SET_ALARM_H -> SET_ALARM_M -> RUN
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      RUN:         n = SET_TIME_H;
      SET_TIME_H:  n = SET_TIME_M;
      SET_TIME_M:  n = SET_ALARM_H;
      SET_ALARM_H: n = SET_ALARM_M;
      default:     n = RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Bundle between the prescaler/debouncers, the controller and the display/buzzer drivers.
//   tick_in, btn_mode, btn_inc, btn_stop  one-cycle strobes into the controller
//   alarm_en                              level enable for alarm/ring/snooze
//   hours, minutes, seconds               time of day
//   alarm_hours, alarm_minutes            alarm setpoint
//   mode, ringing, snoozing               status toward the drivers
// slave: the controller side. master: the side that drives strobes and reads status.
interface alarm_controller_if;
  import alarm_pkg::*;

  logic              tick_in;
  logic              btn_mode;
  logic              btn_inc;
  logic              btn_stop;
  logic              alarm_en;
  logic [HOUR_W-1:0] hours;
  logic [MIN_W-1:0]  minutes;
  logic [SEC_W-1:0]  seconds;
  logic [HOUR_W-1:0] alarm_hours;
  logic [MIN_W-1:0]  alarm_minutes;
  mode_t             mode;
  logic              ringing;
  logic              snoozing;

  modport slave (
    input  tick_in, btn_mode, btn_inc, btn_stop, alarm_en,
    output hours, minutes, seconds, alarm_hours, alarm_minutes, mode, ringing, snoozing
  );

  modport master (
    output tick_in, btn_mode, btn_inc, btn_stop, alarm_en,
    input  hours, minutes, seconds, alarm_hours, alarm_minutes, mode, ringing, snoozing
  );

endinterface

// File: rtl/alarm_controller_mod_counter.sv
// Enable-gated modulo counter: counts 0..MAX and wraps to 0.
//   clk_in, reset_n  clock, async active-low reset
//   en, inc          count advances when both are high
//   clear            synchronous clear, wins over counting
//   count            registered count value
//   wrap_c           combinational strobe: this edge wraps MAX -> 0
module mod_counter #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned MAX   = 59
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             wrap_c
);

  logic at_max_c;

  assign at_max_c = (count == WIDTH'(MAX));
  assign wrap_c   = en & inc & at_max_c & ~clear;

  // Count register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && inc) begin
      count <= at_max_c ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock core: time of day, alarm setpoint, mode FSM, ring and snooze timing.
//   clk_in    system clock
//   reset_n   async active-low reset
//   bus       alarm_controller_if.slave: strobes/enable in, time/alarm/status out
// Parameters: RING_SECONDS ticks of ringing before auto-stop,
//             SNOOZE_MINUTES snooze length (SNOOZE_MINUTES*60 ticks).
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5
) (
  input logic               clk_in,
  input logic               reset_n,
  alarm_controller_if.slave bus
);

  localparam int unsigned SNOOZE_TICKS = SNOOZE_MINUTES * 60;
  localparam int unsigned RING_W       = $clog2(RING_SECONDS + 1);
  localparam int unsigned SNZ_W        = $clog2(SNOOZE_TICKS + 1);

  mode_t             mode_q, mode_d;
  logic [SEC_W-1:0]  sec_q;
  logic [MIN_W-1:0]  min_q;
  logic [HOUR_W-1:0] hr_q;
  logic [HOUR_W-1:0] al_h_q;
  logic [MIN_W-1:0]  al_m_q;

  logic              enter_set_c;
  logic              time_runs_c;
  logic              tick_adv_c;
  logic              inc_eff_c;
  logic              sec_wrap_c, min_wrap_c, hr_wrap_c, ah_wrap_c, am_wrap_c;
  logic              unused_wraps_c;
  logic [MIN_W-1:0]  min_next_c;
  logic [HOUR_W-1:0] hr_next_c;
  logic              trigger_c;

  logic              ringing_q, ringing_d;
  logic              snoozing_q, snoozing_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;

  // Mode state register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode next-state
  always_comb begin
    mode_d = mode_q;
    if (bus.btn_mode) begin
      mode_d = next_mode(mode_q);
    end
  end

  // Entering SET_TIME_H freezes time on that very edge, so the tick is not applied.
  assign enter_set_c = bus.btn_mode && (mode_q == RUN);
  assign time_runs_c = (mode_q == RUN) || (mode_q == SET_ALARM_H) || (mode_q == SET_ALARM_M);
  assign tick_adv_c  = bus.tick_in && time_runs_c && !enter_set_c;
  // A simultaneous mode press swallows the increment.
  assign inc_eff_c   = bus.btn_inc && !bus.btn_mode;

  mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .en      (tick_adv_c),
    .inc     (1'b1),
    .clear   (enter_set_c),
    .count   (sec_q),
    .wrap_c  (sec_wrap_c)
  );

  // Minutes and hours take either the carry chain or a set-mode increment; never both.
  mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .en      (1'b1),
    .inc     (sec_wrap_c || (inc_eff_c && (mode_q == SET_TIME_M))),
    .clear   (1'b0),
    .count   (min_q),
    .wrap_c  (min_wrap_c)
  );

  mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hr (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .en      (1'b1),
    .inc     ((min_wrap_c && sec_wrap_c) || (inc_eff_c && (mode_q == SET_TIME_H))),
    .clear   (1'b0),
    .count   (hr_q),
    .wrap_c  (hr_wrap_c)
  );

  mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_al_h (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .en      (1'b1),
    .inc     (inc_eff_c && (mode_q == SET_ALARM_H)),
    .clear   (1'b0),
    .count   (al_h_q),
    .wrap_c  (ah_wrap_c)
  );

  mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_al_m (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .en      (1'b1),
    .inc     (inc_eff_c && (mode_q == SET_ALARM_M)),
    .clear   (1'b0),
    .count   (al_m_q),
    .wrap_c  (am_wrap_c)
  );

  assign unused_wraps_c = hr_wrap_c ^ ah_wrap_c ^ am_wrap_c;

  // Time after this tick; a match with the current setpoint at :00 fires the alarm.
  always_comb begin
    min_next_c = (min_q == MIN_W'(MIN_MAX)) ? '0 : min_q + MIN_W'(1);
    hr_next_c  = hr_q;
    if (min_q == MIN_W'(MIN_MAX)) begin
      hr_next_c = (hr_q == HOUR_W'(HOUR_MAX)) ? '0 : hr_q + HOUR_W'(1);
    end
  end

  assign trigger_c = sec_wrap_c && bus.alarm_en &&
                     (min_next_c == al_m_q) && (hr_next_c == al_h_q);

  // Ring/snooze registers
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  // Ring/snooze next-state; priority: disable/time-set entry, trigger, stop, timers.
  always_comb begin
    ringing_d  = ringing_q;
    snoozing_d = snoozing_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (!bus.alarm_en || enter_set_c) begin
      ringing_d  = 1'b0;
      snoozing_d = 1'b0;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else if (trigger_c) begin
      ringing_d  = 1'b1;
      snoozing_d = 1'b0;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else if (bus.btn_stop && ringing_q) begin
      ringing_d  = 1'b0;
      snoozing_d = 1'b1;
      snz_cnt_d  = '0;
    end else if (bus.btn_stop && snoozing_q) begin
      snoozing_d = 1'b0;
    end else if (bus.tick_in) begin
      if (ringing_q) begin
        if (ring_cnt_q == RING_W'(RING_SECONDS - 1)) begin
          ringing_d = 1'b0;
        end else begin
          ring_cnt_d = ring_cnt_q + RING_W'(1);
        end
      end
      if (snoozing_q) begin
        if (snz_cnt_q == SNZ_W'(SNOOZE_TICKS - 1)) begin
          snoozing_d = 1'b0;
          ringing_d  = 1'b1;
          ring_cnt_d = '0;
        end else begin
          snz_cnt_d = snz_cnt_q + SNZ_W'(1);
        end
      end
    end
  end

  assign bus.hours         = hr_q;
  assign bus.minutes       = min_q;
  assign bus.seconds       = sec_q;
  assign bus.alarm_hours   = al_h_q;
  assign bus.alarm_minutes = al_m_q;
  assign bus.mode          = mode_q;
  assign bus.ringing       = ringing_q;
  assign bus.snoozing      = snoozing_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus randomized strobes, all checked
// against a seconds-of-day reference model after every clock edge.
module tb_alarm_controller;
  import alarm_pkg::*;

  localparam int RING_S  = 60;
  localparam int SNOOZE  = 5 * 60;
  localparam int DAY_S   = 24 * 3600;

  logic clk_in = 1'b0;
  logic reset_n;

  always #5 clk_in = ~clk_in;

  alarm_controller_if bus ();

  alarm_controller #(.RING_SECONDS(60), .SNOOZE_MINUTES(5)) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  int m_tod, m_ah, m_am, m_mode, m_rt, m_st;
  bit m_ring, m_snz;
  bit en_lvl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("hours",         32'(bus.hours),         32'(m_tod / 3600));
    check("minutes",       32'(bus.minutes),       32'((m_tod / 60) % 60));
    check("seconds",       32'(bus.seconds),       32'(m_tod % 60));
    check("alarm_hours",   32'(bus.alarm_hours),   32'(m_ah));
    check("alarm_minutes", 32'(bus.alarm_minutes), 32'(m_am));
    check("mode",          32'(bus.mode),          32'(m_mode));
    check("ringing",       32'(bus.ringing),       32'(m_ring));
    check("snoozing",      32'(bus.snoozing),      32'(m_snz));
  endtask

  task automatic model_reset();
    m_tod = 0; m_ah = 0; m_am = 0; m_mode = 0;
    m_rt = 0; m_st = 0; m_ring = 0; m_snz = 0;
  endtask

  // One clock edge of the specified behaviour, from the pre-edge state.
  task automatic model_edge(input bit t, input bit bm, input bit bi, input bit bs, input bit en);
    bit enter_set, adv, trig, inc;
    int h, mi;
    enter_set = bm && (m_mode == 0);
    adv  = t && (m_mode == 0 || m_mode == 3 || m_mode == 4) && !enter_set;
    trig = adv && en && (((m_tod + 1) % DAY_S) == m_ah * 3600 + m_am * 60);
    inc  = bi && !bm;
    if (adv) m_tod = (m_tod + 1) % DAY_S;
    h  = m_tod / 3600;
    mi = (m_tod / 60) % 60;
    if (inc) begin
      case (m_mode)
        1: m_tod = ((h + 1) % 24) * 3600 + mi * 60 + m_tod % 60;
        2: m_tod = h * 3600 + ((mi + 1) % 60) * 60 + m_tod % 60;
        3: m_ah  = (m_ah + 1) % 24;
        4: m_am  = (m_am + 1) % 60;
        default: ;
      endcase
    end
    if (enter_set) m_tod = (m_tod / 60) * 60;
    if (bm) m_mode = (m_mode + 1) % 5;
    if (!en || enter_set) begin
      m_ring = 0; m_snz = 0;
    end else if (trig) begin
      m_ring = 1; m_rt = 0; m_snz = 0;
    end else if (bs && m_ring) begin
      m_ring = 0; m_snz = 1; m_st = 0;
    end else if (bs && m_snz) begin
      m_snz = 0;
    end else if (t) begin
      if (m_ring) begin
        m_rt++;
        if (m_rt == RING_S) m_ring = 0;
      end else if (m_snz) begin
        m_st++;
        if (m_st == SNOOZE) begin
          m_snz = 0; m_ring = 1; m_rt = 0;
        end
      end
    end
  endtask

  task automatic step(input bit t, input bit bm, input bit bi, input bit bs);
    @(negedge clk_in);
    bus.tick_in  = t;
    bus.btn_mode = bm;
    bus.btn_inc  = bi;
    bus.btn_stop = bs;
    bus.alarm_en = en_lvl;
    model_edge(t, bm, bi, bs, en_lvl);
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  task automatic to_run();
    while (m_mode != 0) step(0, 1, 0, 0);
  endtask

  // From RUN: walk all set modes with increments and return to RUN.
  task automatic set_all(input int h, input int mi, input int ah, input int am);
    step(0, 1, 0, 0);
    while (m_tod / 3600 != h) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    while ((m_tod / 60) % 60 != mi) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    while (m_ah != ah) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    while (m_am != am) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
  endtask

  initial begin
    int keep_min, rh, rm;
    bus.tick_in = 0; bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_stop = 0;
    bus.alarm_en = 1; en_lvl = 1;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_all();
    @(negedge clk_in);
    reset_n = 1'b1;

    // Reset mid-run at 12:34:56
    set_all(12, 34, 0, 0);
    repeat (56) step(1, 0, 0, 0);
    check("time_12_34_56_sec", 32'(bus.seconds), 32'd56);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("reset_mode_run", 32'(bus.mode), 32'(RUN));
    @(negedge clk_in);
    reset_n = 1'b1;

    // Set hours via buttons; ticks frozen in time-set mode
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    check("set_hours_3", 32'(bus.hours), 32'd3);
    check("set_mode_h", 32'(bus.mode), 32'(SET_TIME_H));
    repeat (5) step(1, 0, 0, 0);
    check("set_ticks_hold_sec", 32'(bus.seconds), 32'd0);
    check("set_ticks_hold_hr", 32'(bus.hours), 32'd3);

    // Hours wrap 23 -> 0 with no carry
    while (m_tod / 3600 != 23) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("hour_wrap", 32'(bus.hours), 32'd0);
    check("hour_wrap_min", 32'(bus.minutes), 32'd0);
    to_run();

    // Midnight rollover
    set_all(23, 58, 12, 0);
    repeat (119) step(1, 0, 0, 0);
    check("pre_midnight_sec", 32'(bus.seconds), 32'd59);
    step(1, 0, 0, 0);
    check("midnight_h", 32'(bus.hours), 32'd0);
    check("midnight_m", 32'(bus.minutes), 32'd0);
    check("midnight_s", 32'(bus.seconds), 32'd0);

    // Alarm trigger and ring timeout
    set_all(6, 59, 7, 0);
    repeat (59) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("trig_ring", 32'(bus.ringing), 32'd1);
    check("trig_hour", 32'(bus.hours), 32'd7);
    repeat (59) step(1, 0, 0, 0);
    check("ring_still", 32'(bus.ringing), 32'd1);
    step(1, 0, 0, 0);
    check("ring_timeout", 32'(bus.ringing), 32'd0);
    check("ring_timeout_snz", 32'(bus.snoozing), 32'd0);

    // Snooze, re-ring, disable
    set_all(6, 59, 7, 0);
    repeat (60) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    check("snooze_on", 32'(bus.snoozing), 32'd1);
    check("snooze_ring_off", 32'(bus.ringing), 32'd0);
    repeat (299) step(1, 0, 0, 0);
    check("snooze_299", 32'(bus.snoozing), 32'd1);
    step(1, 0, 0, 0);
    check("snooze_rering", 32'(bus.ringing), 32'd1);
    check("snooze_done", 32'(bus.snoozing), 32'd0);
    en_lvl = 0;
    step(0, 0, 0, 0);
    check("disable_ring", 32'(bus.ringing), 32'd0);
    en_lvl = 1;

    // Stop coinciding with trigger; stop cancels snooze; idle stop does nothing
    set_all(6, 59, 7, 0);
    repeat (59) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    check("stop_vs_trig_ring", 32'(bus.ringing), 32'd1);
    check("stop_vs_trig_snz", 32'(bus.snoozing), 32'd0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("cancel_snooze", 32'(bus.snoozing), 32'd0);
    step(0, 0, 0, 1);
    check("idle_stop", 32'(bus.ringing), 32'd0);

    // btn_mode + btn_inc together from SET_TIME_M
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    keep_min = (m_tod / 60) % 60;
    step(0, 1, 1, 0);
    check("mode_inc_mode", 32'(bus.mode), 32'(SET_ALARM_H));
    check("mode_inc_min", 32'(bus.minutes), 32'(keep_min));
    to_run();

    // Randomized strobes with the alarm placed one minute ahead
    for (int blk = 0; blk < 8; blk++) begin
      to_run();
      en_lvl = 1;
      rh = int'($urandom_range(0, 23));
      rm = int'($urandom_range(0, 58));
      set_all(rh, rm, rh, rm + 1);
      for (int k = 0; k < 500; k++) begin
        en_lvl = ($urandom_range(0, 99) != 0);
        step($urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
